// File: rtl/pong_pkg.sv
// Shared paddle constants, state encoding, frame layout and small decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pong_pkg;

  localparam int POS_W = 7;
  localparam logic [POS_W-1:0] POS_CENTER = 7'd50;
  localparam logic [POS_W-1:0] POS_MAX    = 7'd99;

  // Link state: IDLE until the first good frame, TRACK while frames keep arriving,
  // LOST after the tick timeout expires with no accepted frame.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LOST  = 2'd2
  } state_t;

  // Frame as delivered by the serial receiver, one decimal digit per byte.
  typedef struct packed {
    logic [7:0] a_tens;
    logic [7:0] a_units;
    logic [7:0] b_tens;
    logic [7:0] b_units;
  } code_t;

  // One position-sized value per player.
  typedef struct packed {
    logic [POS_W-1:0] a;
    logic [POS_W-1:0] b;
  } pair_t;

  // A byte is a legal digit only when it is 0..9.
  function automatic logic digit_ok(input logic [7:0] d);
    return (d <= 8'd9);
  endfunction

  // tens*10+units; callers only use it on legal digits, so the result is 0..99.
  function automatic logic [POS_W-1:0] bcd_to_pos(input logic [7:0] tens,
                                                   input logic [7:0] units);
    return POS_W'(tens * 8'd10 + units);
  endfunction

  // Floor average of two positions, computed one bit wider to keep the carry.
  function automatic logic [POS_W-1:0] pos_avg(input logic [POS_W-1:0] p,
                                                input logic [POS_W-1:0] n);
    return POS_W'(({1'b0, p} + {1'b0, n}) >> 1);
  endfunction

endpackage

// File: rtl/paddle_slew.sv
// Slew-rate limiter: moves one paddle position toward its target by at most STEP per enable.
// Latency: position updates on the clock edge where en is sampled high.
// Backpressure: none; en is a strobe, target is sampled only when en is high.
module paddle_slew
  import pong_pkg::*;
#(
  parameter int STEP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [POS_W-1:0] target,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0] STEP_V = POS_W'(STEP);

  logic [POS_W-1:0] diff_up;
  logic [POS_W-1:0] diff_dn;
  logic [POS_W-1:0] pos_nxt;

  // Next position: snap to target when close enough, otherwise step toward it.
  always_comb begin
    diff_up = target - pos;
    diff_dn = pos - target;
    pos_nxt = pos;
    if (target > pos) begin
      pos_nxt = (diff_up <= STEP_V) ? target : pos + STEP_V;
    end else if (target < pos) begin
      pos_nxt = (diff_dn <= STEP_V) ? target : pos - STEP_V;
    end
    // Targets are already bounded; this keeps the court limit local to the limiter.
    if (pos_nxt > POS_MAX) begin
      pos_nxt = POS_MAX;
    end
  end

  // Position register, centred on reset, advanced only on enabled ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= POS_CENTER;
    end else if (en) begin
      pos <= pos_nxt;
    end
  end

endmodule

// File: rtl/paddle_track.sv
// Paddle tracker: validates digit frames, sets per-player targets, slews paddles on a prescaled tick, watches link timeout.
// Latency: frame_ok/frame_err and target one cycle after code_stb; positions move on ticks; link_lost lags state by one cycle.
// Backpressure: none; every code_stb is consumed. Optional PADDLE_FILTER_EN averages each new value with the previous accepted one.
module paddle_track
  import pong_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      code,
  input  logic             code_stb,
  output logic [POS_W-1:0] pos_a,
  output logic [POS_W-1:0] pos_b,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [7:0]       err_cnt,
  output logic             link_lost
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  code_t          fr;
  logic           bytes_ok;
  logic           accept;
  logic           reject;
  pair_t          raw;
  pair_t          tgt;
  pair_t          tgt_nxt;
  logic [PW-1:0]  pcnt;
  logic           tick;
  state_t         state;
  logic [TW-1:0]  tcnt;
  logic           move_en;

  assign fr = code;

  // Frame check and digit-pair decode, evaluated in the strobe cycle.
  always_comb begin
    bytes_ok = digit_ok(fr.a_tens) && digit_ok(fr.a_units) &&
               digit_ok(fr.b_tens) && digit_ok(fr.b_units);
    raw.a    = bcd_to_pos(fr.a_tens, fr.a_units);
    raw.b    = bcd_to_pos(fr.b_tens, fr.b_units);
  end

  assign accept = code_stb & bytes_ok;
  assign reject = code_stb & ~bytes_ok;

`ifdef PADDLE_FILTER_EN
  pair_t prev;
  logic  have_prev;

  // Smoothed target: mean of the previous accepted value and this one; the first frame loads directly.
  always_comb begin
    tgt_nxt = raw;
    if (have_prev) begin
      tgt_nxt.a = pos_avg(prev.a, raw.a);
      tgt_nxt.b = pos_avg(prev.b, raw.b);
    end
  end

  // Remember the raw accepted values (not the smoothed ones) for the next average.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '{a: POS_CENTER, b: POS_CENTER};
      have_prev <= 1'b0;
    end else if (accept) begin
      prev      <= raw;
      have_prev <= 1'b1;
    end
  end
`else
  // Unfiltered target: the latest accepted value.
  always_comb begin
    tgt_nxt = raw;
  end
`endif

  // Frame outcome pulses, target register and saturating reject counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 8'd0;
      tgt       <= '{a: POS_CENTER, b: POS_CENTER};
    end else begin
      frame_ok  <= accept;
      frame_err <= reject;
      if (accept) begin
        tgt <= tgt_nxt;
      end
      if (reject && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Free-running prescaler; tick is high for the last count of each period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (pcnt == PRE_LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick = (pcnt == PRE_LAST);

  // Link FSM with tick-based timeout; link_lost registers the pre-edge state so it trails by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      link_lost <= 1'b1;
    end else begin
      link_lost <= (state != TRACK);
      case (state)
        IDLE: begin
          if (accept) begin
            state <= TRACK;
            tcnt  <= '0;
          end
        end
        TRACK: begin
          if (accept) begin
            tcnt <= '0;
          end else if (tick) begin
            if (tcnt == TO_LAST) begin
              state <= LOST;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        LOST: begin
          if (accept) begin
            state <= TRACK;
            tcnt  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          tcnt  <= '0;
        end
      endcase
    end
  end

  // Paddles only move on ticks while tracking; the registered target seen here predates any same-cycle load.
  assign move_en = tick && (state == TRACK);

  paddle_slew #(.STEP(STEP)) u_slew_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (move_en),
    .target (tgt.a),
    .pos    (pos_a)
  );

  paddle_slew #(.STEP(STEP)) u_slew_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (move_en),
    .target (tgt.b),
    .pos    (pos_b)
  );

endmodule
